// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared RISC-V widths, fetch FSM states, boot address and response record
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
package instr_fetch_pkg;
   localparam int WORD_W = `RISCV_WORD_WIDTH;
   localparam int ADDR_W = `RISCV_ADDR_WIDTH;
   localparam logic [ADDR_W-1:0] DEF_BOOT_ADDR = ADDR_W'(32'h0000_0080);
   typedef enum logic {FETCH_RUN, FETCH_REDIR_WAIT} fetch_state_e;
   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [ADDR_W-1:0] addr;
   } fetch_resp_t;
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_resp_fifo.sv
// fetch_resp_fifo: in-order queue of returned instruction words with their word addresses
module fetch_resp_fifo import instr_fetch_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_resp_t   din,
   output fetch_resp_t   dout,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   fetch_resp_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign do_push = push && !flush;
   assign do_pop = pop && !flush && !empty;
   assign dout = mem[rd_ptr];
   // Flush empties the queue and wins over a push or pop in the same cycle
   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: word fetch with bounded in-flight requests, redirect handling and buffer drain
module instr_fetch import instr_fetch_pkg::*; #(
   parameter int                DEPTH     = 2,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = DEF_BOOT_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              halt_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_gnt_i,
   input  logic              instr_rvalid_i,
   input  logic [WORD_W-1:0] instr_rdata_i,
   output logic              buf_clear_o,
   output logic              buf_read_offset_o,
   output logic              buf_write_en_o,
   output logic [WORD_W-1:0] buf_instr_o,
   output logic [ADDR_W-1:0] buf_addr_o,
   input  logic              buf_full_i
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = CW + 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW:0] LIMIT = LW'(DEPTH);
   fetch_state_e state, state_nx;
   logic [ADDR_W-1:0] fetch_addr, fetch_addr_nx, target, target_nx;
   logic [CW-1:0] out_cnt, out_nx, disc_cnt, disc_nx, fifo_cnt;
   logic req_hold, gnt, stall, drop, push, pop, fifo_empty, fifo_full, in_wait;
   logic [ADDR_W-1:0] aq [DEPTH];
   logic [PW-1:0] aq_wr, aq_rd;
   fetch_resp_t fifo_din, fifo_dout;
   assign instr_addr_o = fetch_addr;
   assign buf_instr_o = fifo_dout.word;
   assign buf_addr_o = fifo_dout.addr;
   assign fifo_din = '{word: instr_rdata_i, addr: aq[aq_rd]};
   // Request gate, response routing, redirect bookkeeping and next-state selection
   always_comb begin
      in_wait = state == FETCH_REDIR_WAIT;
      instr_req_o = !rst && (in_wait || req_hold || (!halt_i && {1'b0, out_cnt} + {1'b0, fifo_cnt} < LIMIT));
      gnt = instr_req_o && instr_gnt_i;
      stall = instr_req_o && !instr_gnt_i;
      drop = instr_rvalid_i && disc_cnt != '0;
      push = instr_rvalid_i && !drop && !branch_i;
      buf_write_en_o = !rst && !fifo_empty && !branch_i;
      pop = buf_write_en_o && !buf_full_i;
      buf_clear_o = branch_i || rst;
      buf_read_offset_o = rst ? BOOT_ADDR[1] : branch_addr_i[1];
      out_nx = out_cnt + CW'(gnt) - CW'(instr_rvalid_i);
      disc_nx = branch_i ? out_nx : disc_cnt + CW'(gnt && in_wait) - CW'(drop);
      target_nx = branch_i ? branch_addr_i : target;
      state_nx = stall && (branch_i || in_wait) ? FETCH_REDIR_WAIT : FETCH_RUN;
      fetch_addr_nx = stall ? fetch_addr : (branch_i || in_wait) ? word_align(target_nx) : gnt ? fetch_addr + ADDR_W'(4) : fetch_addr;
   end
   // FSM state, fetch address, redirect target and in-flight counters
   always_ff @(posedge clk)
      if (rst) begin
         state <= FETCH_RUN;
         fetch_addr <= word_align(BOOT_ADDR);
         target <= '0;
         out_cnt <= '0;
         disc_cnt <= '0;
         req_hold <= 1'b0;
      end else begin
         state <= state_nx;
         fetch_addr <= fetch_addr_nx;
         target <= target_nx;
         out_cnt <= out_nx;
         disc_cnt <= disc_nx;
         req_hold <= stall;
      end
   // Address tags written at grant and consumed by every response, dropped or not
   always_ff @(posedge clk)
      if (rst) begin
         aq_wr <= '0;
         aq_rd <= '0;
      end else begin
         if (gnt) begin
            aq[aq_wr] <= instr_addr_o;
            aq_wr <= aq_wr == LAST ? '0 : aq_wr + 1'b1;
         end
         if (instr_rvalid_i)
            aq_rd <= aq_rd == LAST ? '0 : aq_rd + 1'b1;
      end
   // A response must always find room; the request gate reserves it at issue time
   always_ff @(posedge clk)
      if (!rst)
         assert (!(push && fifo_full));
   fetch_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (branch_i),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios for the fetch stage with hand-computed expectations
module tb_instr_fetch;
   import instr_fetch_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic branch_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic halt_i = 1'b0;
   logic instr_req_o;
   logic [31:0] instr_addr_o;
   logic instr_gnt_i = 1'b0;
   logic instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic buf_clear_o, buf_read_offset_o, buf_write_en_o;
   logic [31:0] buf_instr_o, buf_addr_o;
   logic buf_full_i = 1'b0;
   int checks = 0;
   int passed = 0;
   always #5 clk = ~clk;
   instr_fetch #(.DEPTH(2), .BOOT_ADDR(32'h0000_0080)) dut (
      .clk               (clk),
      .rst               (rst),
      .branch_i          (branch_i),
      .branch_addr_i     (branch_addr_i),
      .halt_i            (halt_i),
      .instr_req_o       (instr_req_o),
      .instr_addr_o      (instr_addr_o),
      .instr_gnt_i       (instr_gnt_i),
      .instr_rvalid_i    (instr_rvalid_i),
      .instr_rdata_i     (instr_rdata_i),
      .buf_clear_o       (buf_clear_o),
      .buf_read_offset_o (buf_read_offset_o),
      .buf_write_en_o    (buf_write_en_o),
      .buf_instr_o       (buf_instr_o),
      .buf_addr_o        (buf_addr_o),
      .buf_full_i        (buf_full_i)
   );
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      branch_i = 1'b0;
      branch_addr_i = '0;
      halt_i = 1'b0;
      instr_gnt_i = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i = '0;
      buf_full_i = 1'b0;
      @(negedge clk);
      #1;
   endtask
   task automatic cycle(input logic b, input logic [31:0] ba, input logic h, input logic g, input logic rv, input logic [31:0] rd, input logic f);
      @(negedge clk);
      rst = 1'b0;
      branch_i = b;
      branch_addr_i = ba;
      halt_i = h;
      instr_gnt_i = g;
      instr_rvalid_i = rv;
      instr_rdata_i = rd;
      buf_full_i = f;
      #1;
   endtask
   task automatic test_reset();
      do_reset();
      checks++; if (instr_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", instr_req_o); else passed++;
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL rst_wen: got %b want 0", buf_write_en_o); else passed++;
      checks++; if (buf_clear_o !== 1'b1) $display("FAIL rst_clear: got %b want 1", buf_clear_o); else passed++;
      checks++; if (buf_read_offset_o !== 1'b0) $display("FAIL rst_offset: got %b want 0", buf_read_offset_o); else passed++;
      checks++; if (instr_addr_o !== 32'h80) $display("FAIL rst_addr: got %h want 00000080", instr_addr_o); else passed++;
   endtask
   task automatic test_basic();
      do_reset();
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL basic_req: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h80) $display("FAIL basic_addr0: got %h want 00000080", instr_addr_o); else passed++;
      checks++; if (buf_clear_o !== 1'b0) $display("FAIL basic_clear: got %b want 0", buf_clear_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'h0001_0001, 0);
      checks++; if (instr_addr_o !== 32'h84) $display("FAIL basic_addr1: got %h want 00000084", instr_addr_o); else passed++;
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL basic_nobypass: got %b want 0", buf_write_en_o); else passed++;
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b1) $display("FAIL basic_wen: got %b want 1", buf_write_en_o); else passed++;
      checks++; if (buf_instr_o !== 32'h0001_0001) $display("FAIL basic_instr: got %h want 00010001", buf_instr_o); else passed++;
      checks++; if (buf_addr_o !== 32'h80) $display("FAIL basic_baddr: got %h want 00000080", buf_addr_o); else passed++;
   endtask
   task automatic test_full();
      do_reset();
      cycle(0, 0, 0, 1, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 32'hAAAA_0080, 1);
      checks++; if (instr_addr_o !== 32'h84) $display("FAIL full_addr1: got %h want 00000084", instr_addr_o); else passed++;
      cycle(0, 0, 0, 1, 1, 32'hAAAA_0084, 1);
      checks++; if (instr_req_o !== 1'b0) $display("FAIL full_req_drop: got %b want 0", instr_req_o); else passed++;
      checks++; if (buf_write_en_o !== 1'b1) $display("FAIL full_wen_held: got %b want 1", buf_write_en_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b0) $display("FAIL full_req_two_q: got %b want 0", instr_req_o); else passed++;
      checks++; if (buf_instr_o !== 32'hAAAA_0080) $display("FAIL full_instr0: got %h want aaaa0080", buf_instr_o); else passed++;
      checks++; if (buf_addr_o !== 32'h80) $display("FAIL full_baddr0: got %h want 00000080", buf_addr_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_instr_o !== 32'hAAAA_0084) $display("FAIL full_instr1: got %h want aaaa0084", buf_instr_o); else passed++;
      checks++; if (buf_addr_o !== 32'h84) $display("FAIL full_baddr1: got %h want 00000084", buf_addr_o); else passed++;
      checks++; if (instr_req_o !== 1'b1) $display("FAIL full_req_resume: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h88) $display("FAIL full_addr_resume: got %h want 00000088", instr_addr_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL full_drained: got %b want 0", buf_write_en_o); else passed++;
   endtask
   task automatic test_branch();
      do_reset();
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(1, 32'h102, 0, 0, 0, 0, 0);
      checks++; if (buf_clear_o !== 1'b1) $display("FAIL br_clear: got %b want 1", buf_clear_o); else passed++;
      checks++; if (buf_read_offset_o !== 1'b1) $display("FAIL br_offset: got %b want 1", buf_read_offset_o); else passed++;
      checks++; if (instr_req_o !== 1'b0) $display("FAIL br_req_full: got %b want 0", instr_req_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'hDEAD_0080, 0);
      checks++; if (buf_clear_o !== 1'b0) $display("FAIL br_clear_off: got %b want 0", buf_clear_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'hDEAD_0084, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL br_req_new: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h100) $display("FAIL br_addr_new: got %h want 00000100", instr_addr_o); else passed++;
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL br_drop0: got %b want 0", buf_write_en_o); else passed++;
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL br_drop1: got %b want 0", buf_write_en_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'h1234_5678, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b1) $display("FAIL br_wen_new: got %b want 1", buf_write_en_o); else passed++;
      checks++; if (buf_instr_o !== 32'h1234_5678) $display("FAIL br_instr_new: got %h want 12345678", buf_instr_o); else passed++;
      checks++; if (buf_addr_o !== 32'h100) $display("FAIL br_baddr_new: got %h want 00000100", buf_addr_o); else passed++;
   endtask
   task automatic test_redir_wait();
      do_reset();
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 32'h0A0A_0080, 0);
      cycle(0, 0, 0, 0, 1, 32'h0B0B_0084, 0);
      checks++; if (buf_instr_o !== 32'h0A0A_0080) $display("FAIL rw_instr0: got %h want 0a0a0080", buf_instr_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_addr_o !== 32'h84) $display("FAIL rw_baddr1: got %h want 00000084", buf_addr_o); else passed++;
      checks++; if (instr_addr_o !== 32'h88) $display("FAIL rw_addr_pre: got %h want 00000088", instr_addr_o); else passed++;
      cycle(1, 32'h200, 0, 0, 0, 0, 0);
      checks++; if (buf_clear_o !== 1'b1) $display("FAIL rw_clear: got %b want 1", buf_clear_o); else passed++;
      checks++; if (buf_read_offset_o !== 1'b0) $display("FAIL rw_offset: got %b want 0", buf_read_offset_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL rw_req_hold: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h88) $display("FAIL rw_addr_hold: got %h want 00000088", instr_addr_o); else passed++;
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++; if (instr_addr_o !== 32'h88) $display("FAIL rw_addr_gnt: got %h want 00000088", instr_addr_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'h0BAD_0088, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL rw_req_new: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h200) $display("FAIL rw_addr_new: got %h want 00000200", instr_addr_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL rw_dropped: got %b want 0", buf_write_en_o); else passed++;
   endtask
   task automatic test_branch_rvalid();
      do_reset();
      cycle(0, 0, 0, 1, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 32'hCAFE_0080, 1);
      cycle(1, 32'h300, 0, 0, 1, 32'hCAFE_0084, 1);
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL brv_wen_same: got %b want 0", buf_write_en_o); else passed++;
      checks++; if (buf_clear_o !== 1'b1) $display("FAIL brv_clear: got %b want 1", buf_clear_o); else passed++;
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL brv_wen_after: got %b want 0", buf_write_en_o); else passed++;
      checks++; if (instr_req_o !== 1'b1) $display("FAIL brv_req: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h300) $display("FAIL brv_addr: got %h want 00000300", instr_addr_o); else passed++;
      cycle(0, 0, 0, 0, 1, 32'hF00D_0300, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (buf_instr_o !== 32'hF00D_0300) $display("FAIL brv_instr: got %h want f00d0300", buf_instr_o); else passed++;
      checks++; if (buf_addr_o !== 32'h300) $display("FAIL brv_baddr: got %h want 00000300", buf_addr_o); else passed++;
   endtask
   task automatic test_halt();
      do_reset();
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL halt_hold: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h80) $display("FAIL halt_addr: got %h want 00000080", instr_addr_o); else passed++;
      cycle(0, 0, 1, 1, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL halt_gnt: got %b want 1", instr_req_o); else passed++;
      cycle(0, 0, 1, 0, 1, 32'h0000_1111, 0);
      checks++; if (instr_req_o !== 1'b0) $display("FAIL halt_req0: got %b want 0", instr_req_o); else passed++;
      cycle(0, 0, 1, 0, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b0) $display("FAIL halt_req1: got %b want 0", instr_req_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (instr_req_o !== 1'b1) $display("FAIL halt_resume: got %b want 1", instr_req_o); else passed++;
      checks++; if (instr_addr_o !== 32'h84) $display("FAIL halt_addr_resume: got %h want 00000084", instr_addr_o); else passed++;
   endtask
   task automatic test_wrap();
      do_reset();
      cycle(1, 32'hFFFF_FFFE, 0, 1, 0, 0, 0);
      checks++; if (buf_read_offset_o !== 1'b1) $display("FAIL wrap_offset: got %b want 1", buf_read_offset_o); else passed++;
      cycle(0, 0, 0, 1, 1, 32'h5555_0080, 0);
      checks++; if (instr_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want fffffffc", instr_addr_o); else passed++;
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (instr_addr_o !== 32'h0) $display("FAIL wrap_zero: got %h want 00000000", instr_addr_o); else passed++;
      checks++; if (buf_write_en_o !== 1'b0) $display("FAIL wrap_drop: got %b want 0", buf_write_en_o); else passed++;
   endtask
   initial begin
      test_reset();
      test_basic();
      test_full();
      test_branch();
      test_redir_wait();
      test_branch_rvalid();
      test_halt();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the realign buffer. Issues word-aligned requests on the instruction-memory request/grant/rvalid bus, keeps up to `DEPTH` transactions in flight, and queues returned words in a small response FIFO that drains into the realign buffer's write port under its `full` back-pressure. On a control-flow redirect it clears the realign buffer with the correct half-word read offset, flushes its own queue, and discards responses that are still in flight for the old stream.

## Interface
- `DEPTH`, 2: maximum in-flight requests plus queued responses; power of two, ≥1.
- `BOOT_ADDR`, 32'h0000_0080: first fetch address after reset; bit 0 must be 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `branch_i` in 1: redirect pulse, one cycle.
- `branch_addr_i` in `RISCV_ADDR_WIDTH`: redirect target, half-word aligned.
- `halt_i` in 1: stops new requests.
- `instr_req_o` out 1: memory request.
- `instr_addr_o` out `RISCV_ADDR_WIDTH`: request address; bits [1:0] are always 0.
- `instr_gnt_i` in 1: request accepted.
- `instr_rvalid_i` in 1: response valid.
- `instr_rdata_i` in `RISCV_WORD_WIDTH`: response word.
- `buf_clear_o` out 1: realign buffer clear.
- `buf_read_offset_o` out 1: start half-word for the buffer after a clear.
- `buf_write_en_o` out 1: a word is offered to the buffer.
- `buf_instr_o` out `RISCV_WORD_WIDTH`: offered word.
- `buf_addr_o` out `RISCV_ADDR_WIDTH`: word address of the offered word.
- `buf_full_i` in 1: buffer cannot accept a write.

## Operation
- Registers:
  - `fetch_addr`: next word to request.
  - `out_cnt`: granted requests without a response (0..DEPTH).
  - `disc_cnt`: in-flight responses to drop (0..DEPTH).
  - Response FIFO: DEPTH entries of {word, address}.
  - `target`: saved redirect address.
- States:
  - RUN: `instr_req_o = !halt_i && (out_cnt + fifo_cnt < DEPTH)`. On grant, `fetch_addr += 4`, wrapping modulo 2^ADDR.
  - REDIR_WAIT: holds a request that was asserted but not granted when the redirect arrived. `instr_req_o = 1` and the address is the old address, unchanged. On grant, the response is counted into `disc_cnt`, `fetch_addr` takes `{target[ADDR-1:2], 2'b00}`, and the state returns to RUN.
- Once asserted, a request keeps `instr_req_o` high and the address stable until granted. `halt_i` does not withdraw a request that is already asserted.
- Response handling on rvalid:
  - If `disc_cnt > 0`, drop the word and decrement `disc_cnt`.
  - Otherwise push {rdata, address}. The address comes from a parallel in-order FIFO, or equivalent, that is written at grant.
- Drain:
  - `buf_write_en_o` = FIFO not empty and not `branch_i`.
  - Pop when `buf_write_en_o && !buf_full_i`.
- Redirect (`branch_i`):
  - Combinational outputs in the same cycle: `buf_clear_o = 1` and `buf_read_offset_o = branch_addr_i[1]`.
  - The FIFO is flushed.
  - `disc_cnt` is set to `out_cnt + gnt_this_cycle − (rvalid_this_cycle && disc_cnt == 0 ? 1 : 0)`, adjusted for any drop in the same cycle. A response arriving in the same cycle as the redirect is always dropped.
  - If a request is asserted and not granted in that cycle, save `target` and go to REDIR_WAIT. Otherwise set `fetch_addr` to the aligned target and stay in RUN.
  - A redirect during REDIR_WAIT only overwrites `target`.
- `buf_clear_o = branch_i | rst`. While `rst` is high, `buf_read_offset_o = BOOT_ADDR[1]`.

## Timing
- Reset values:
  - `instr_req_o` = 0, `buf_write_en_o` = 0, `buf_clear_o` = 1, `buf_read_offset_o` = `BOOT_ADDR[1]`.
  - `instr_addr_o` = `{BOOT_ADDR[ADDR-1:2], 2'b00}`.
  - Counters and FIFO empty; state RUN.
- The first request is asserted in the first cycle after `rst` falls.
- Memory returns responses in order, at least one cycle after grant.
- Latency: rvalid in cycle N gives `buf_write_en_o` in cycle N+1 with that word, provided the buffer is not full. There is no combinational bypass.
- Full back-pressure: the FIFO holds up to DEPTH words. The request gate keeps `out_cnt + fifo_cnt ≤ DEPTH`, so rvalid never arrives while the FIFO is full. Overflow is an assertion failure.
- Redirect-to-new-request latency: 1 cycle from RUN. From REDIR_WAIT, 1 cycle after the old grant.
- Reset asserted mid-transaction abandons all counts. The memory side is also reset.

## Structure
- Width macros come from `riscv_defines.sv`: `RISCV_WORD_WIDTH`, `RISCV_ADDR_WIDTH`.
- Add to the shared defines: the FSM state enum (`FETCH_RUN`, `FETCH_REDIR_WAIT`) and the default `BOOT_ADDR`.
- One sub-module, `fetch_resp_fifo`: a synchronous FIFO of {word, addr} with push, pop, flush, count, empty and full.

## Test plan
- Reset with `BOOT_ADDR=0x80`: request at 0x80, grant; rvalid with 0x0001_0001 in cycle N gives `buf_write_en_o=1`, `buf_instr_o=0x0001_0001`, `buf_addr_o=0x80` in N+1. The next request is at 0x84.
- `buf_full_i=1` with grants and rvalids every cycle: two words are queued and `instr_req_o` drops. Release `buf_full_i`: 0x80 and 0x84 are written in order and requests resume at 0x88.
- Two requests outstanding, `branch_i` with target 0x102: same cycle `buf_clear_o=1`, `buf_read_offset_o=1`. Both stale rvalids are dropped and the next request goes to 0x100.
- Redirect to 0x200 while the request at 0x88 is held without grant: the request stays at 0x88 until granted, its data is dropped, then the request goes to 0x200.
- `branch_i` and `instr_rvalid_i` in the same cycle: no `buf_write_en_o` follows for that word.
- `halt_i=1` while a request is ungranted: the request is held until grant, then `instr_req_o=0` until `halt_i` falls.
